wb_cmd_master: RTL

- Wishbone classic initiator that turns single commands into bus cycles, e.g. for test or logic-analyser access to the timer peripherals.
- It is the initiator counterpart to the project's Wishbone responder path: it accepts a command on a valid/ready port and runs one single-beat read or write with cyc/stb.
- It waits for ack or a timeout, then returns read data and an error flag on a valid/ready response port.

---
 rtl/wb_cmd_master_if.sv | 43 ++++
 rtl/wb_cmd_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone initiator signals of wb_cmd_master.
// The master modport is the view taken by wb_cmd_master itself; the slave
// modport is the view of whatever drives commands and plays the responder.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    logic [7:0]  err_cnt_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output err_cnt_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  err_cnt_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns one accepted command into a single-beat
// read or write, waits for ack or a bounded number of stb cycles, and hands
// the result back on a valid/ready response port. At most one transaction is
// ever outstanding. Every output comes straight from a register.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    wb_cmd_master_if.master  cmd_if
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  wait_q, wait_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State and all output registers; reset clears everything, including
    // any bus cycle or response in flight and the timeout counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= 8'h0;
            wait_q      <= 8'h0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            wait_q      <= wait_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                // Ready rises on the first edge out of reset; acceptance
                // needs the registered ready, so that edge cannot accept.
                cmd_ready_d = 1'b1;
                if (cmd_if.cmd_valid_i && cmd_ready_q) begin
                    we_d        = cmd_if.cmd_we_i;
                    sel_d       = cmd_if.cmd_sel_i;
                    adr_d       = cmd_if.cmd_adr_i;
                    dat_d       = cmd_if.cmd_dat_i;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    wait_d      = 8'd1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (cmd_if.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : cmd_if.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wait_q == TIMEOUT_LIM) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : ERR_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    err_cnt_d   = sat_inc(err_cnt_q);
                    state_d     = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (cmd_if.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_if.cmd_ready_o = cmd_ready_q;
    assign cmd_if.rsp_valid_o = rsp_valid_q;
    assign cmd_if.rsp_dat_o   = rsp_dat_q;
    assign cmd_if.rsp_err_o   = rsp_err_q;
    assign cmd_if.wbm_cyc_o   = cyc_q;
    assign cmd_if.wbm_stb_o   = cyc_q;
    assign cmd_if.wbm_we_o    = we_q;
    assign cmd_if.wbm_sel_o   = sel_q;
    assign cmd_if.wbm_adr_o   = adr_q;
    assign cmd_if.wbm_dat_o   = dat_q;
    assign cmd_if.err_cnt_o   = err_cnt_q;

endmodule
